// File: rtl/aes_ctr_ctrl.sv
// CTR-mode sequencer sitting in front of aes_core. It loads the key, then
// turns each accepted data block into one counter-block encryption and XORs
// the returned keystream onto the held data. Encryption and decryption are
// the same operation.
//
// Streams use plain valid/ready: a transfer happens on a rising clk edge
// where valid and ready are both 1; a source holds valid and its payload
// steady until that edge, and ready never waits on valid.
//
// dbg_state encodings: 0 IDLE, 1 KINIT, 2 KWAIT, 3 RUN, 4 ISSUE, 5 CWAIT.
module aes_ctr_ctrl #(
  parameter int CTR_WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [255:0] key_in,
  input  logic         keylen_in,
  input  logic         key_load,
  input  logic [127:0] iv,
  input  logic         start,
  output logic         key_valid,
  output logic         busy,
  input  logic [127:0] s_data,
  input  logic         s_valid,
  input  logic         s_last,
  output logic         s_ready,
  output logic [127:0] m_data,
  output logic         m_valid,
  output logic         m_last,
  input  logic         m_ready,
  output logic         core_encdec,
  output logic         core_init,
  output logic         core_next,
  output logic [255:0] core_key,
  output logic         core_keylen,
  output logic [127:0] core_block,
  input  logic         core_ready,
  input  logic [127:0] core_result,
  input  logic         core_result_valid,
  output logic [2:0]   dbg_state
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] KINIT = 3'd1;
  localparam logic [2:0] KWAIT = 3'd2;
  localparam logic [2:0] RUN   = 3'd3;
  localparam logic [2:0] ISSUE = 3'd4;
  localparam logic [2:0] CWAIT = 3'd5;

  // Bits of the counter block that advance per block; the rest stay fixed.
  localparam logic [127:0] CTR_MASK = (CTR_WIDTH >= 128) ? {128{1'b1}} :
                                      ((128'd1 << CTR_WIDTH) - 128'd1);

  logic [2:0]   state;
  logic [127:0] counter;
  logic [127:0] counter_inc;
  logic [127:0] held_data;
  logic         held_last;
  logic         s_fire;
  logic         m_fire;

  // Input is taken only while streaming and the output register can take a
  // result, counting the slot freed by a same-cycle downstream drain.
  assign s_ready     = (state == RUN) && (!m_valid || m_ready);
  assign s_fire      = s_valid && s_ready;
  assign m_fire      = m_valid && m_ready;
  assign counter_inc = (counter & ~CTR_MASK) | ((counter + 128'd1) & CTR_MASK);

  assign core_encdec = 1'b1;
  assign core_block  = counter;
  assign busy        = (state != IDLE);
  assign dbg_state   = state;

  // Sequencer: key expansion, block issue and output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      key_valid   <= 1'b0;
      m_valid     <= 1'b0;
      m_last      <= 1'b0;
      m_data      <= '0;
      core_init   <= 1'b0;
      core_next   <= 1'b0;
      core_key    <= '0;
      core_keylen <= 1'b0;
      counter     <= '0;
      held_data   <= '0;
      held_last   <= 1'b0;
    end else begin
      core_init <= 1'b0;
      core_next <= 1'b0;
      if (m_fire) m_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (key_load) begin
            core_key    <= key_in;
            core_keylen <= keylen_in;
            key_valid   <= 1'b0;
            core_init   <= 1'b1;
            state       <= KINIT;
          end else if (start && key_valid) begin
            counter <= iv;
            state   <= RUN;
          end
        end
        KINIT: state <= KWAIT;
        KWAIT: begin
          if (core_ready) begin
            key_valid <= 1'b1;
            state     <= IDLE;
          end
        end
        RUN: begin
          if (s_fire) begin
            held_data <= s_data;
            held_last <= s_last;
            core_next <= 1'b1;
            state     <= ISSUE;
          end else if (start) begin
            counter <= iv;
          end
        end
        ISSUE: state <= CWAIT;
        CWAIT: begin
          if (core_ready && core_result_valid) begin
            m_data  <= held_data ^ core_result;
            m_last  <= held_last;
            m_valid <= 1'b1;
            counter <= counter_inc;
            state   <= held_last ? IDLE : RUN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/aes_ctr_ctrl.md
Name: aes_ctr_ctrl

Overview:
- Counter-mode (CTR) sequencer that sits directly upstream of aes_core and drives its init/next/block interface.
- Accepts a stream of 128-bit data blocks on a valid/ready handshake and issues the counter block to the core, which always runs in encipher mode.
- XORs the returned keystream with the held data block and presents the result on an output valid/ready stream.
- The same flow encrypts and decrypts.

Parameters:
CTR_WIDTH, 32, number of low-order counter bits incremented per block (1..128); upper 128-CTR_WIDTH bits are held constant.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
key_in  in  256  cipher key; a 128-bit key occupies [255:128]
keylen_in  in  1  0 = 128-bit key, 1 = 256-bit key
key_load  in  1  pulse: capture key and run core key expansion
iv  in  128  initial counter block
start  in  1  pulse: load iv into counter and enter streaming
key_valid  out  1  key expansion complete
busy  out  1  not IDLE
s_data  in  128  input block
s_valid  in  1  input valid
s_last  in  1  final block of message
s_ready  out  1  input accepted when s_valid & s_ready
m_data  out  128  output block
m_valid  out  1  output valid
m_last  out  1  final block marker
m_ready  in  1  downstream accepts
core_encdec  out  1  tied 1
core_init  out  1  registered pulse to core init
core_next  out  1  registered pulse to core next
core_key  out  256  registered key
core_keylen  out  1  registered keylen
core_block  out  128  current counter block
core_ready  in  1  core ready
core_result  in  128  core result
core_result_valid  in  1  core result valid

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-high.
- Reset values: state=IDLE; key_valid, m_valid, m_last, core_init, core_next, s_ready=0; counter, m_data, core_key=0; core_keylen=0.
- Reset mid-operation abandons any block in flight; no output is produced for it.
- States: IDLE, KINIT, KWAIT, RUN, ISSUE, CWAIT.
- IDLE, key_load=1: register key_in/keylen_in; clear key_valid; go KINIT.
  - key_load takes priority over a simultaneous start.
- IDLE, start=1 and key_valid=1: counter<=iv; go RUN.
  - start with key_valid=0 is ignored.
- key_load and start are ignored in every state other than IDLE (and RUN for start, see below).
- KINIT: core_init=1 for exactly this cycle; go KWAIT.
- KWAIT: on core_ready=1, set key_valid=1 and go IDLE.
- RUN: s_ready = !m_valid | m_ready.
  - On accept: latch s_data/s_last; go ISSUE.
  - start in RUN with no accept restarts the counter from iv. An accept takes priority over start.
- ISSUE: core_next=1 for one cycle with core_block=counter; go CWAIT.
- CWAIT: on core_ready & core_result_valid:
  - m_data <= held ^ core_result, m_last <= held_last, m_valid <= 1.
  - counter low CTR_WIDTH bits += 1, modulo 2^CTR_WIDTH; upper bits unchanged.
  - Go IDLE if held_last, else RUN.
- Latency: accept at cycle N → core_next at N+1 → m_valid one cycle after the core signals ready.
- Output register: m_valid holds, with m_data/m_last stable, until m_ready=1.
  - A new accept is allowed in the same cycle m_ready drains the register.
- s_ready=0 in every state except RUN.
- core_key, core_keylen and core_block are stable whenever the core is busy.

Test Plan:
- Key expansion: key_load with key_in[255:128]=2b7e151628aed2a6abf7158809cf4f3c, keylen=0 → one core_init pulse, then key_valid=1 after core_ready, busy returns 0.
- SP800-38A F.5.1 block 1: start with iv=f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, s_data=6bc1bee22e409f96e93d7e117393172a → m_data=874d6191b620e3261bef6864990db6ce.
- Block 2 carry: next s_data=ae2d8a571e03ac9c9eb76fac45af8e51 → core_block=f0f1f2f3f4f5f6f7f8f9fafbfcfdff00, m_data=9806f66b7970fdff8617187bb9fffdff; with s_last=1, m_last=1 and state returns to IDLE.
- Counter wrap: iv=00112233_44556677_8899aabb_ffffffff, two blocks → second core_block=00112233_44556677_8899aabb_00000000 (upper 96 bits unchanged).
- Backpressure: hold m_ready=0 for 10 cycles after m_valid → m_data stable, s_ready=0, exactly one core_next issued; on m_ready=1, s_ready rises in the same cycle.
- Reset and ignored commands:
  - reset asserted in CWAIT → next cycle state IDLE, m_valid=0, key_valid=0.
  - start with key_valid=0 → busy stays 0, no core_next.
